osu_data_check: RTL

Receive-side checker for the 384-bit OSU test stream produced by the OSU data generator. It tracks OSU framing (one header beat followed by three payload beats per 192-byte OSU), verifies the 7-byte all-zero header and the incrementing modulo-256 payload byte sequence, and reports per-frame pass/fail plus saturating frame and error counters. It sits at the far end of the OSU datapath, after the link or loopback under test.

---
 rtl/osu_pkg.sv | 18 +
 rtl/osu_seq_cmp.sv | 24 ++
 rtl/osu_data_check.sv | 126 ++++++++++++
 3 files changed

// File: rtl/osu_pkg.sv
// Shared OSU stream constants, FSM state type and lane accessor.
package osu_pkg;

    localparam int unsigned OSU_BEAT_W            = 384;
    localparam int unsigned OSU_BEAT_BYTES        = 48;
    localparam int unsigned OSU_HDR_BYTES         = 7;
    localparam int unsigned OSU_BEATS             = 4;
    localparam int unsigned OSU_HDR_PAYLOAD_BYTES = 41;

    typedef enum logic {HUNT, LOCKED} osu_state_e;

    // Lane 0 is the most significant byte (first on the wire).
    function automatic logic [7:0] osu_lane(input logic [OSU_BEAT_W-1:0] beat,
                                            input int unsigned           k);
        return beat[OSU_BEAT_W-1-8*k -: 8];
    endfunction

endpackage

// File: rtl/osu_seq_cmp.sv
// Combinational check of a beat against an ascending byte sequence from a seed.
module osu_seq_cmp
    import osu_pkg::*;
(
    input  logic [OSU_BEAT_W-1:0] beat,
    input  logic [7:0]            seed,
    input  logic [5:0]            first_lane,
    output logic                  mismatch,
    output logic                  hdr_zero
);

    always_comb begin
        mismatch = 1'b0;
        hdr_zero = 1'b1;
        for (int unsigned k = 0; k < OSU_BEAT_BYTES; k++) begin
            if (k < OSU_HDR_BYTES && osu_lane(beat, k) != 8'h00)
                hdr_zero = 1'b0;
            if (k >= 32'(first_lane) &&
                osu_lane(beat, k) != seed + 8'(k) - 8'(first_lane))
                mismatch = 1'b1;
        end
    end

endmodule

// File: rtl/osu_data_check.sv
// OSU receive checker: frame lock, header/payload sequence check, frame and error counters.
module osu_data_check
    import osu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [OSU_BEAT_W-1:0] in_data,
    output logic                  locked,
    output logic                  frame_done,
    output logic                  frame_good,
    output logic                  hdr_err,
    output logic                  pay_err,
    output logic [CNT_W-1:0]      frame_count,
    output logic [CNT_W-1:0]      err_count
);

    osu_state_e state, state_next;
    logic [1:0] beat_idx, beat_idx_next;
    logic [7:0] exp_byte, exp_byte_next;
    logic       frame_bad, frame_bad_next;

    logic hunt_mismatch, hunt_hdr_zero;
    logic trk_mismatch, trk_hdr_zero;
    logic done_next, good_next, hdr_next, pay_next, err_inc;

    // Hunt search seeds from the beat's own lane 7 to find any header-like beat.
    osu_seq_cmp u_hunt_cmp (
        .beat       (in_data),
        .seed       (osu_lane(in_data, OSU_HDR_BYTES)),
        .first_lane (6'(OSU_HDR_BYTES)),
        .mismatch   (hunt_mismatch),
        .hdr_zero   (hunt_hdr_zero)
    );

    osu_seq_cmp u_trk_cmp (
        .beat       (in_data),
        .seed       (exp_byte),
        .first_lane ((beat_idx == 2'd0) ? 6'(OSU_HDR_BYTES) : 6'd0),
        .mismatch   (trk_mismatch),
        .hdr_zero   (trk_hdr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            beat_idx  <= '0;
            exp_byte  <= '0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_next;
            beat_idx  <= beat_idx_next;
            exp_byte  <= exp_byte_next;
            frame_bad <= frame_bad_next;
        end
    end

    always_comb begin
        state_next     = state;
        beat_idx_next  = beat_idx;
        exp_byte_next  = exp_byte;
        frame_bad_next = frame_bad;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (hunt_hdr_zero && !hunt_mismatch) begin
                        state_next     = LOCKED;
                        beat_idx_next  = 2'd1;
                        exp_byte_next  = osu_lane(in_data, OSU_BEAT_BYTES - 1) + 8'd1;
                        frame_bad_next = 1'b0;
                    end
                end
                LOCKED: begin
                    if (beat_idx == 2'd0 && !trk_hdr_zero) begin
                        state_next    = HUNT;
                        beat_idx_next = 2'd0;
                    end else begin
                        exp_byte_next  = exp_byte + ((beat_idx == 2'd0) ?
                                         8'(OSU_HDR_PAYLOAD_BYTES) : 8'(OSU_BEAT_BYTES));
                        frame_bad_next = frame_bad | trk_mismatch;
                        if (beat_idx == 2'(OSU_BEATS - 1)) begin
                            beat_idx_next  = 2'd0;
                            frame_bad_next = 1'b0;
                        end else begin
                            beat_idx_next = beat_idx + 2'd1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_comb begin
        hdr_next  = in_valid && state == LOCKED && beat_idx == 2'd0 && !trk_hdr_zero;
        pay_next  = in_valid && state == LOCKED && !hdr_next && trk_mismatch;
        done_next = in_valid && state == LOCKED && beat_idx == 2'(OSU_BEATS - 1);
        good_next = done_next && !(frame_bad || trk_mismatch);
        err_inc   = hdr_next || (done_next && !good_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_good  <= 1'b0;
            hdr_err     <= 1'b0;
            pay_err     <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            locked     <= (state_next == LOCKED);
            frame_done <= done_next;
            frame_good <= good_next;
            hdr_err    <= hdr_next;
            pay_err    <= pay_next;
            if (done_next && frame_count != '1)
                frame_count <= frame_count + 1'b1;
            if (err_inc && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

endmodule
